life_gen_ctrl: RTL and testbench
================================

Name: life_gen_ctrl

Overview:
- Generation sequencer and state register for the Game of Life datapath.
- Holds the current grid, which feeds the combinational evolve datapath, and accepts that datapath's `grid_next` back.
- Commits a new generation on single-step or on a free-running divided tick.
- Counts generations and halts when the pattern becomes still life.

Parameters:
- N, 8: grid side length; the grid is N*N bits, with cell (r,c) at bit r*N+c.
- DIV, 4: clock cycles per generation in RUN mode, must be >= 1.
- GEN_W, 16: width of the generation counter.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- seed  input  N*N  initial pattern, captured on load.
- load  input  1  pulse; copy seed into grid.
- start  input  1  pulse; enter free-running evolution.
- stop  input  1  pulse; leave free-running evolution.
- step  input  1  pulse; commit exactly one generation while IDLE.
- grid_next  input  N*N  next generation computed by the evolve datapath from grid.
- grid  output  N*N  current generation, driven to the evolve datapath.
- gen_count  output  GEN_W  generations committed since the last load.
- running  output  1  high while in RUN.
- stable  output  1  high while in HALT.

Behaviour:
- Reset (reset=0, asynchronous):
  - grid=0, gen_count=0, tick counter=0, state=IDLE.
  - running=0, stable=0.
  - All outputs are registered.
- States: IDLE, RUN, HALT.
  - running = (state==RUN).
  - stable = (state==HALT).
- Command priority in one cycle: load > stop > start > step. Lower-priority commands in the same cycle are ignored.
- load (any state):
  - grid<=seed, gen_count<=0, tick<=0, state<=IDLE on the next edge.
- Commit event:
  - If grid_next==grid: grid unchanged, gen_count unchanged, state<=HALT.
  - Otherwise: grid<=grid_next, gen_count<=gen_count+1 (saturates at all-ones, no wrap), state unchanged.
  - An all-zero grid evolves to zero, so it halts on its first commit.
- IDLE:
  - start -> RUN, tick<=0.
  - step -> one commit; the result is visible the next cycle.
  - Otherwise hold.
- RUN:
  - tick increments each cycle.
  - When tick==DIV-1: commit and tick<=0.
  - The first commit occurs DIV cycles after the start edge.
  - stop -> IDLE, tick<=0, no commit that cycle even if tick==DIV-1.
  - step is ignored.
- HALT:
  - grid and gen_count are frozen.
  - start, step and stop are ignored.
  - Only load or reset leaves HALT.
- Reset asserted mid-RUN clears everything immediately; no partial commit.
- DIV=1: commit every cycle while in RUN.

Optional Feature:
- Macro: LIFE_PERIOD2_DETECT_EN.
- Enabled:
  - An extra N*N register prev holds the grid from before the last committed change.
  - prev is cleared by reset and by load.
  - A commit where grid_next==prev, and gen_count>=2 after the increment, still updates grid and increments gen_count, then enters HALT.
  - Effect: period-2 oscillators halt with stable=1.
- Disabled:
  - No prev register.
  - Only still lifes halt; oscillators run indefinitely.

Test Plan:
- Reset then idle: reset=0 for 2 cycles, release -> grid=64'h0, gen_count=0, running=0, stable=0. Then step -> HALT after one cycle, gen_count stays 0.
- Blinker stepping (bench pairs the DUT with the evolve datapath), feature off:
  - load seed=64'h0000_0000_1C00_0000, then step -> grid=64'h0000_0008_0808_0000, gen_count=1.
  - step again -> grid=64'h0000_0000_1C00_0000, gen_count=2, stable=0.
- Still life in RUN, DIV=4: load block 64'h0000_0018_1800_0000, start -> 4 cycles later stable=1, running=0, gen_count=0, grid unchanged. Then start and step -> no change.
- Stop and priority:
  - Blinker in RUN: assert stop on the cycle with tick==3 -> no commit, state=IDLE.
  - Assert load and start in the same cycle -> grid=seed, state=IDLE, gen_count=0.
- Asynchronous reset mid-run: drop reset between clock edges while in RUN -> grid=0 and running=0 immediately, without waiting for a clock edge.
- With LIFE_PERIOD2_DETECT_EN, blinker in RUN -> stable=1 after the second commit, gen_count=2, grid=64'h0000_0000_1C00_0000.

Source files
------------

// File: rtl/life_gen_ctrl.sv
// rtl/life_gen_ctrl.sv - Game of Life generation sequencer and grid state register
//
// Purpose:
//   Holds the current generation, hands it to the external evolve datapath and
//   commits the returned next generation on a single step (IDLE) or on every
//   DIV-th cycle (RUN). Counts committed generations and parks in HALT once the
//   pattern stops changing.
//
// Optional feature macro: LIFE_PERIOD2_DETECT_EN
//   When defined, the previous generation is also kept so that period-2
//   oscillators are detected and halted as well.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   seed       in   N*N initial pattern, captured on load
//   load       in   pulse: grid <= seed, counters cleared, back to IDLE
//   start      in   pulse: enter free-running evolution
//   stop       in   pulse: leave free-running evolution
//   step       in   pulse: commit one generation while IDLE
//   grid_next  in   N*N next generation from the evolve datapath
//   grid       out  N*N current generation
//   gen_count  out  GEN_W generations committed since last load (saturating)
//   running    out  high while in RUN
//   stable     out  high while in HALT

module life_gen_ctrl #(
   parameter int N     = 8,
   parameter int DIV   = 4,
   parameter int GEN_W = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N*N-1:0]     seed,
   input  logic               load,
   input  logic               start,
   input  logic               stop,
   input  logic               step,
   input  logic [N*N-1:0]     grid_next,
   output logic [N*N-1:0]     grid,
   output logic [GEN_W-1:0]   gen_count,
   output logic               running,
   output logic               stable
);

   localparam int CELLS  = N * N;
   localparam int TICK_W = (DIV > 1) ? $clog2(DIV) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

   state_t             state, state_d;
   logic [CELLS-1:0]   grid_d;
   logic [GEN_W-1:0]   gen_d;
   logic [GEN_W-1:0]   gen_inc;
   logic [TICK_W-1:0]  tick, tick_d;
   logic               commit;
   logic               still;
   logic               p2_hit;

   // Saturating increment: the counter sticks at all-ones instead of wrapping.
   assign gen_inc = (&gen_count) ? gen_count : gen_count + 1'b1;
   assign still   = (grid_next == grid);

`ifdef LIFE_PERIOD2_DETECT_EN
   logic [CELLS-1:0] prev, prev_d;

   // Requiring at least two generations keeps a freshly loaded pattern from
   // matching the cleared prev register.
   assign p2_hit = (grid_next == prev) && (gen_inc >= GEN_W'(2));
`else
   assign p2_hit = 1'b0;
`endif

   always_comb begin
      state_d = state;
      grid_d  = grid;
      gen_d   = gen_count;
      tick_d  = tick;
      commit  = 1'b0;
`ifdef LIFE_PERIOD2_DETECT_EN
      prev_d  = prev;
`endif

      if (load) begin
         grid_d  = seed;
         gen_d   = '0;
         tick_d  = '0;
         state_d = IDLE;
`ifdef LIFE_PERIOD2_DETECT_EN
         prev_d  = '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               // stop outranks start/step, so it swallows them while doing nothing itself
               if (stop) begin
                  state_d = IDLE;
               end else if (start) begin
                  state_d = RUN;
                  tick_d  = '0;
               end else if (step) begin
                  commit = 1'b1;
               end
            end
            RUN: begin
               if (stop) begin
                  state_d = IDLE;
                  tick_d  = '0;
               end else if (tick == TICK_W'(DIV - 1)) begin
                  commit = 1'b1;
                  tick_d = '0;
               end else begin
                  tick_d = tick + 1'b1;
               end
            end
            HALT: begin
               state_d = HALT;
            end
            default: begin
               state_d = IDLE;
            end
         endcase

         if (commit) begin
            if (still) begin
               state_d = HALT;
            end else begin
               grid_d = grid_next;
               gen_d  = gen_inc;
`ifdef LIFE_PERIOD2_DETECT_EN
               prev_d = grid;
`endif
               if (p2_hit) begin
                  state_d = HALT;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         grid      <= '0;
         gen_count <= '0;
         tick      <= '0;
         running   <= 1'b0;
         stable    <= 1'b0;
      end else begin
         state     <= state_d;
         grid      <= grid_d;
         gen_count <= gen_d;
         tick      <= tick_d;
         running   <= (state_d == RUN);
         stable    <= (state_d == HALT);
      end
   end

`ifdef LIFE_PERIOD2_DETECT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prev <= '0;
      end else begin
         prev <= prev_d;
      end
   end
`endif

endmodule

// File: tb/tb_life_gen_ctrl.sv
// tb/tb_life_gen_ctrl.sv - self-checking bench for life_gen_ctrl with a Life evolve model

module tb_life_gen_ctrl;

   localparam int N     = 8;
   localparam int DIV   = 4;
   localparam int GEN_W = 16;

   localparam logic [63:0] BLINK_H = 64'h0000_0000_1C00_0000;
   localparam logic [63:0] BLINK_V = 64'h0000_0008_0808_0000;
   localparam logic [63:0] BLOCK   = 64'h0000_0018_1800_0000;

   logic              clk;
   logic              reset;
   logic [63:0]       seed;
   logic              load, start, stop, step;
   logic [63:0]       grid_next;
   logic [63:0]       grid;
   logic [GEN_W-1:0]  gen_count;
   logic              running;
   logic              stable;

   int checks = 0;
   int errors = 0;

   life_gen_ctrl #(.N(N), .DIV(DIV), .GEN_W(GEN_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .seed      (seed),
      .load      (load),
      .start     (start),
      .stop      (stop),
      .step      (step),
      .grid_next (grid_next),
      .grid      (grid),
      .gen_count (gen_count),
      .running   (running),
      .stable    (stable)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Conway rule on a bounded 8x8 field; cells beyond the edge are dead.
   function automatic logic [63:0] evolve(input logic [63:0] g);
      logic [63:0] nx;
      nx = '0;
      for (int r = 0; r < N; r++) begin
         for (int c = 0; c < N; c++) begin
            int cnt;
            cnt = 0;
            for (int dr = -1; dr <= 1; dr++) begin
               for (int dc = -1; dc <= 1; dc++) begin
                  if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < N &&
                      c + dc >= 0 && c + dc < N && g[(r + dr) * N + c + dc])
                     cnt++;
               end
            end
            nx[r * N + c] = (cnt == 3) || (g[r * N + c] && cnt == 2);
         end
      end
      return nx;
   endfunction

   // The evolve datapath the controller is paired with.
   assign grid_next = evolve(grid);

   // Behavioural model: mode 0=idle 1=run 2=halt, cyc counts cycles since the
   // last run-start or commit.
   logic [63:0] m_grid, m_prev;
   int          m_gen, m_mode, m_cyc;

   task automatic m_commit();
      logic [63:0] nx;
      int          g1;
      nx = evolve(m_grid);
      if (nx == m_grid) begin
         m_mode = 2;
      end else begin
         g1 = (m_gen == 65535) ? m_gen : m_gen + 1;
`ifdef LIFE_PERIOD2_DETECT_EN
         if (nx == m_prev && g1 >= 2) m_mode = 2;
`endif
         m_prev = m_grid;
         m_grid = nx;
         m_gen  = g1;
      end
   endtask

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_grid = '0; m_prev = '0; m_gen = 0; m_mode = 0; m_cyc = 0;
      end else if (load) begin
         m_grid = seed; m_prev = '0; m_gen = 0; m_mode = 0; m_cyc = 0;
      end else if (m_mode == 0) begin
         if (!stop && start) begin
            m_mode = 1; m_cyc = 0;
         end else if (!stop && step) begin
            m_commit();
         end
      end else if (m_mode == 1) begin
         if (stop) begin
            m_mode = 0; m_cyc = 0;
         end else begin
            m_cyc++;
            if (m_cyc == DIV) begin
               m_cyc = 0;
               m_commit();
            end
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      #2;
      check("model_grid",    grid,               m_grid);
      check("model_gen",     64'(gen_count),     64'(m_gen));
      check("model_running", 64'(running),       64'(m_mode == 1));
      check("model_stable",  64'(stable),        64'(m_mode == 2));
   end

   task automatic pulse(input logic l, input logic sa, input logic so, input logic st);
      load = l; start = sa; stop = so; step = st;
      @(negedge clk);
      load = 1'b0; start = 1'b0; stop = 1'b0; step = 1'b0;
   endtask

   initial begin
      reset = 1'b0; seed = '0;
      load = 1'b0; start = 1'b0; stop = 1'b0; step = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("rst_grid",    grid,           64'h0);
      check("rst_gen",     64'(gen_count), 64'd0);
      check("rst_running", 64'(running),   64'd0);
      check("rst_stable",  64'(stable),    64'd0);

      pulse(0, 0, 0, 1);
      check("zero_halt",   64'(stable),    64'd1);
      check("zero_gen",    64'(gen_count), 64'd0);

      // Blinker single steps
      seed = BLINK_H;
      pulse(1, 0, 0, 0);
      check("load_grid",   grid,           BLINK_H);
      check("load_stable", 64'(stable),    64'd0);
      pulse(0, 0, 0, 1);
      check("step1_grid",  grid,           BLINK_V);
      check("step1_gen",   64'(gen_count), 64'd1);
      pulse(0, 0, 0, 1);
      check("step2_grid",  grid,           BLINK_H);
      check("step2_gen",   64'(gen_count), 64'd2);
`ifdef LIFE_PERIOD2_DETECT_EN
      check("step2_stable", 64'(stable),   64'd1);
`else
      check("step2_stable", 64'(stable),   64'd0);
`endif

      // Still life in RUN
      seed = BLOCK;
      pulse(1, 0, 0, 0);
      pulse(0, 1, 0, 0);
      check("block_running", 64'(running), 64'd1);
      repeat (3) @(negedge clk);
      check("block_pre_stable", 64'(stable), 64'd0);
      @(negedge clk);
      check("block_stable",  64'(stable),    64'd1);
      check("block_running0", 64'(running),  64'd0);
      check("block_gen",     64'(gen_count), 64'd0);
      check("block_grid",    grid,           BLOCK);
      pulse(0, 1, 0, 0);
      pulse(0, 0, 0, 1);
      check("halt_hold_stable", 64'(stable), 64'd1);
      check("halt_hold_grid",   grid,        BLOCK);

      // Stop on the commit cycle
      seed = BLINK_H;
      pulse(1, 0, 0, 0);
      pulse(0, 1, 0, 0);
      repeat (3) @(negedge clk);
      pulse(0, 0, 1, 0);
      check("stop_grid",    grid,           BLINK_H);
      check("stop_gen",     64'(gen_count), 64'd0);
      check("stop_running", 64'(running),   64'd0);
      pulse(0, 0, 0, 1);
      check("stop_then_step", grid,         BLINK_V);

      // load beats start
      pulse(0, 1, 0, 0);
      seed = BLOCK;
      pulse(1, 1, 0, 0);
      check("prio_grid",    grid,           BLOCK);
      check("prio_gen",     64'(gen_count), 64'd0);
      check("prio_running", 64'(running),   64'd0);

      // Asynchronous reset mid-run
      seed = BLINK_H;
      pulse(1, 0, 0, 0);
      pulse(0, 1, 0, 0);
      repeat (5) @(negedge clk);
      @(posedge clk);
      #3 reset = 1'b0;
      #1;
      check("async_grid",    grid,           64'h0);
      check("async_running", 64'(running),   64'd0);
      check("async_gen",     64'(gen_count), 64'd0);
      @(negedge clk);
      reset = 1'b1;

      // Blinker free-running
      seed = BLINK_H;
      pulse(1, 0, 0, 0);
      pulse(0, 1, 0, 0);
`ifdef LIFE_PERIOD2_DETECT_EN
      repeat (8) @(negedge clk);
      check("osc_stable",  64'(stable),    64'd1);
      check("osc_gen",     64'(gen_count), 64'd2);
      check("osc_grid",    grid,           BLINK_H);
`else
      repeat (12) @(negedge clk);
      check("osc_running", 64'(running),   64'd1);
      check("osc_gen",     64'(gen_count), 64'd3);
      check("osc_grid",    grid,           BLINK_V);
`endif
      pulse(0, 0, 1, 0);
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
